power_output_seq: RTL and testbench

Parametrised power-sequenced output stage for the appliance controller. A level `power_on` request brings `CH` output channels up one at a time in ascending order and takes them down in descending order, with a fixed step spacing. Each channel's `W`-bit data is passed through only while that channel is enabled. It sits between the control FSM/display logic and the board pins, replacing ad-hoc `power_on` gating of outputs. It adds sequencing, mid-ramp reversal, an emergency force-off and status reporting.

---
 rtl/power_output_seq_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/power_output_seq.sv | 140 ++++++++++++++
 tb/tb_power_output_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/power_output_seq_pkg.sv
// Shared definitions for the power-sequenced output stage: FSM state encodings
// (OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3) and small helpers reused by the FSM and display logic.
package power_output_seq_pkg;

    typedef enum logic [1:0] {
        StOff      = 2'd0,
        StRampUp   = 2'd1,
        StOn       = 2'd2,
        StRampDown = 2'd3
    } pwr_state_e;

    function automatic logic is_ramp(pwr_state_e s);
        return (s == StRampUp) || (s == StRampDown);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/power_output_seq.sv
// Power-sequenced output stage: ramps CH channel enables up/down in thermometer order with a
// fixed step spacing, gates per-channel data by its enable, supports reversal and force-off.
module power_output_seq
    import power_output_seq_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned STEP_CYC = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            power_on,
    input  logic            force_off,
    input  logic [CH*W-1:0] ch_data_in,
    output logic [CH*W-1:0] ch_data_out,
    output logic [CH-1:0]   ch_en,
    output logic            pwr_ready,
    output logic            busy,
    output logic [1:0]      state
);

    localparam int unsigned CW = $clog2(STEP_CYC + 1);
    localparam logic [CW-1:0] CntLast = CW'(STEP_CYC - 1);

    logic            power_s;
    pwr_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CH-1:0]   en_q, en_d;
    logic [CH-1:0]   en_up, en_dn;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            step;
    logic [CH*W-1:0] gated;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (power_on),
        .q   (power_s)
    );

    // Thermometer code: stepping up sets the lowest clear bit, stepping down clears the highest.
    assign en_up = (en_q << 1) | CH'(1'b1);
    assign en_dn = en_q >> 1;
    assign step  = (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
            cnt_q   <= '0;
            en_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        unique case (state_q)
            StOff: begin
                cnt_d = '0;
                if (power_s) begin
                    en_d    = en_up;
                    state_d = (&en_up) ? StOn : StRampUp;
                end
            end
            StRampUp: begin
                if (!power_s) begin
                    // Reversal wins over a pending step on the same edge.
                    en_d    = en_dn;
                    cnt_d   = '0;
                    state_d = (en_dn == '0) ? StOff : StRampDown;
                end else if (step) begin
                    en_d    = en_up;
                    cnt_d   = '0;
                    state_d = (&en_up) ? StOn : StRampUp;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StOn: begin
                cnt_d = '0;
                if (!power_s) begin
                    en_d    = en_dn;
                    state_d = (en_dn == '0) ? StOff : StRampDown;
                end
            end
            StRampDown: begin
                if (power_s) begin
                    en_d    = en_up;
                    cnt_d   = '0;
                    state_d = (&en_up) ? StOn : StRampUp;
                end else if (step) begin
                    en_d    = en_dn;
                    cnt_d   = '0;
                    state_d = (en_dn == '0) ? StOff : StRampDown;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
        if (force_off) begin
            state_d = StOff;
            cnt_d   = '0;
            en_d    = '0;
        end
    end

    always_comb begin
        ready_d = (state_d == StOn);
        busy_d  = is_ramp(state_d);
    end

    // Gating uses the current enable register, so data lags the enable by one edge.
    for (genvar i = 0; i < int'(CH); i++) begin : g_gate
        assign gated[i*W +: W] = en_q[i] ? ch_data_in[i*W +: W] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_data_out <= '0;
        end else begin
            ch_data_out <= gated;
        end
    end

    assign ch_en     = en_q;
    assign pwr_ready = ready_q;
    assign busy      = busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_power_output_seq.sv
// Self-checking bench for power_output_seq: directed scenarios then random stimulus, all
// compared each cycle against a level/mode reference model.
module tb_power_output_seq;

    localparam int unsigned CH       = 4;
    localparam int unsigned W        = 8;
    localparam int unsigned STEP_CYC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          power_on = 1'b0;
    logic          force_off = 1'b0;
    logic [31:0]   din = 32'hDDCCBBAA;
    logic [31:0]   dout;
    logic [3:0]    ch_en;
    logic          pwr_ready;
    logic          busy;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;

    // Reference model: number of enabled channels, mode 0..3, step timer, synchroniser stages.
    int          m_mode = 0;
    int          m_lvl  = 0;
    int          m_cnt  = 0;
    bit          m_s1   = 1'b0;
    bit          m_s2   = 1'b0;
    logic [31:0] m_data = '0;

    power_output_seq #(
        .CH       (CH),
        .W        (W),
        .STEP_CYC (STEP_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .power_on    (power_on),
        .force_off   (force_off),
        .ch_data_in  (din),
        .ch_data_out (dout),
        .ch_en       (ch_en),
        .pwr_ready   (pwr_ready),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gate(int lvl, logic [31:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < int'(CH); i++)
            if (i < lvl) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic int mode_after_up(int lvl);
        return (lvl == int'(CH)) ? 2 : 1;
    endfunction

    function automatic int mode_after_down(int lvl);
        return (lvl == 0) ? 0 : 3;
    endfunction

    task automatic model_update();
        logic [31:0] nd;
        if (rst) begin
            m_mode = 0; m_lvl = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_data = '0;
            return;
        end
        nd = gate(m_lvl, din);
        if (force_off) begin
            m_mode = 0; m_lvl = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_cnt = 0;
                    if (m_s2) begin m_lvl = 1; m_mode = mode_after_up(m_lvl); end
                end
                1: begin
                    if (!m_s2) begin
                        m_lvl--; m_cnt = 0; m_mode = mode_after_down(m_lvl);
                    end else if (m_cnt == int'(STEP_CYC) - 1) begin
                        m_lvl++; m_cnt = 0; m_mode = mode_after_up(m_lvl);
                    end else m_cnt++;
                end
                2: begin
                    m_cnt = 0;
                    if (!m_s2) begin m_lvl--; m_mode = mode_after_down(m_lvl); end
                end
                default: begin
                    if (m_s2) begin
                        m_lvl++; m_cnt = 0; m_mode = mode_after_up(m_lvl);
                    end else if (m_cnt == int'(STEP_CYC) - 1) begin
                        m_lvl--; m_cnt = 0; m_mode = mode_after_down(m_lvl);
                    end else m_cnt++;
                end
            endcase
        end
        m_data = nd;
        m_s2 = m_s1;
        m_s1 = power_on;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("ch_en", {28'b0, ch_en}, 32'((1 << m_lvl) - 1));
        check("state", {30'b0, state}, 32'(m_mode));
        check("pwr_ready", {31'b0, pwr_ready}, {31'b0, m_mode == 2});
        check("busy", {31'b0, busy}, {31'b0, (m_mode == 1) || (m_mode == 3)});
        check("ch_data_out", dout, m_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        bit ok;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_en", {28'b0, ch_en}, 32'h0);
        check("reset_state", {30'b0, state}, 32'h0);

        // Power-up: T0 is the first edge after power_on rises.
        power_on = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 2)  check("pu_t2", {28'b0, ch_en}, 32'h1);
            if (k == 5)  check("pu_t5", {28'b0, ch_en}, 32'h3);
            if (k == 8)  check("pu_t8", {28'b0, ch_en}, 32'h7);
            if (k == 11) check("pu_t11", {27'b0, pwr_ready, ch_en}, 32'h1F);
            if (k == 12) check("pu_t12_data", dout, 32'hDDCCBBAA);
        end
        repeat (3) tick();

        // Power-down from ON.
        power_on = 1'b0;
        repeat (16) tick();
        check("pd_off", {30'b0, state}, 32'h0);

        // Reversal mid ramp-up.
        power_on = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (ch_en == 4'b0011) && (state == 2'd1);
        end
        check("rev_reach_0011", {31'b0, ok}, 32'h1);
        power_on = 1'b0;
        repeat (3) tick();
        check("rev_down", {26'b0, state, ch_en}, {26'b0, 2'd3, 4'b0001});
        power_on = 1'b1;
        repeat (3) tick();
        check("rev_up", {26'b0, state, ch_en}, {26'b0, 2'd1, 4'b0011});

        // Force-off in ON with power_on held.
        repeat (10) tick();
        force_off = 1'b1;
        tick();
        check("fo_off", {25'b0, pwr_ready, state, ch_en}, 32'h0);
        force_off = 1'b0;
        tick();
        check("fo_restart", {26'b0, state, ch_en}, {26'b0, 2'd1, 4'b0001});

        // Synchronous reset mid ramp-down.
        repeat (12) tick();
        power_on = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_down", {dout[27:0] | {24'b0, busy, pwr_ready, state}, ch_en}, 32'h0);
        repeat (5) begin
            tick();
            check("rst_held_en", {28'b0, ch_en}, 32'h0);
        end
        rst = 1'b0;
        repeat (3) tick();

        // One-cycle glitch on power_on from OFF.
        power_on = 1'b1;
        tick();
        power_on = 1'b0;
        repeat (6) begin
            tick();
            check("glitch_en_le1", {31'b0, ch_en > 4'b0001}, 32'h0);
        end
        check("glitch_off", {30'b0, state}, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) power_on = ~power_on;
            force_off = ($urandom_range(39) == 0);
            rst       = ($urandom_range(199) == 0);
            din       = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
